// File: rtl/dm_access_pkg.sv
// rtl/dm_access_pkg.sv - shared defaults and FSM state constants for the DM access master
package dm_access_pkg;

  localparam int DM_N_DEFAULT       = 7;
  localparam int DM_TIMEOUT_DEFAULT = 15;

  typedef logic [1:0] dm_state_t;

  localparam dm_state_t ST_IDLE  = 2'd0;
  localparam dm_state_t ST_ISSUE = 2'd1;
  localparam dm_state_t ST_WAIT  = 2'd2;
  localparam dm_state_t ST_RESP  = 2'd3;

endpackage

// File: rtl/dm_access_timeout.sv
// rtl/dm_access_timeout.sv - WAIT-cycle counter; instantiated only under DM_ACCESS_TIMEOUT_EN
module dm_access_timeout #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Fires in the cycle whose increment brings the count to TIMEOUT.
  assign expired = en && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dm_access_master.sv
// rtl/dm_access_master.sv - pipeline-to-DM load/store initiator
// Optional load timeout enabled by defining DM_ACCESS_TIMEOUT_EN.
module dm_access_master
  import dm_access_pkg::*;
#(
  parameter int N       = DM_N_DEFAULT,
  parameter int TIMEOUT = DM_TIMEOUT_DEFAULT
) (
  input  logic          clka,
  input  logic          resetn,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [N-1:0]  req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic          ena,
  output logic          wea,
  output logic [N-1:0]  addra,
  output logic [31:0]   dina,
  input  logic [31:0]   douta,
  input  logic          done
);

  dm_state_t   state_q, state_d;
  logic        we_q, we_d;
  logic [N-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        timed_out;

`ifdef DM_ACCESS_TIMEOUT_EN
  dm_access_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clka),
    .resetn  (resetn),
    .clr     (state_q != ST_WAIT),
    .en      ((state_q == ST_WAIT) && !done),
    .expired (timed_out)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT != 0);
  assign timed_out          = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // done beats a timeout landing in the same cycle.
        if (done) begin
          rdata_d = douta;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (timed_out) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      default: begin
        if (resp_ready) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clka) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // All outputs come from registers or state only.
  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign ena        = (state_q == ST_ISSUE);
  assign wea        = (state_q == ST_ISSUE) && we_q;
  assign addra      = addr_q;
  assign dina       = wdata_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule
